// File: rtl/pc_pkg.sv
// pc_pkg: shared widths, reset PC default and FSM state encoding for the PC sequencer
package pc_pkg;
  localparam int PC_W = 32;
  localparam int JT_W = 26;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {RUN = 2'd0, ARMED = 2'd1, DONE = 2'd2, HALT = 2'd3} pc_state_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and PC/status outputs of the fetch-stage PC sequencer
interface pc_sequencer_if;
  import pc_pkg::*;
  logic run_mode;
  logic push;
  logic stall;
  logic branch_taken;
  logic [PC_W-1:0] branch_offset;
  logic jump;
  logic [JT_W-1:0] jump_target;
  logic halt_req;
  logic [PC_W-1:0] pc;
  logic pc_adv;
  logic [1:0] state;
  logic halted;
  modport master(
    output run_mode, push, stall, branch_taken, branch_offset, jump, jump_target, halt_req,
    input pc, pc_adv, state, halted
  );
  modport slave(
    input run_mode, push, stall, branch_taken, branch_offset, jump, jump_target, halt_req,
    output pc, pc_adv, state, halted
  );
endinterface

// File: rtl/pc_next_calc.sv
// pc_next_calc: successor PC mux (jump over branch over sequential), all arithmetic modulo 2^32
module pc_next_calc
  import pc_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            jump,
  input  logic [JT_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_offset,
  output logic [PC_W-1:0] pc_next
);
  logic [PC_W-1:0] pc_plus1;
  assign pc_plus1 = pc + 32'd1;
  assign pc_next = jump ? {pc_plus1[PC_W-1:JT_W], jump_target}
                 : branch_taken ? pc_plus1 + branch_offset
                 : pc_plus1;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC FSM with stall, sticky halt and optional single-step mode (macro PC_STEP_EN)
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input logic clk,
  input logic reset,
  pc_sequencer_if.slave b
);
  pc_state_e st, st_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic pc_adv, opp, take, adv;
  pc_next_calc u_calc (
    .pc           (pc),
    .jump         (b.jump),
    .jump_target  (b.jump_target),
    .branch_taken (b.branch_taken),
    .branch_offset(b.branch_offset),
    .pc_next      (pc_nxt)
  );
`ifdef PC_STEP_EN
  logic push_q, pending, pending_nxt, step;
  assign step = pending | (b.push & ~push_q);
  // push edge history and a step request that survives stalls
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      push_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      push_q  <= b.push;
      pending <= pending_nxt;
    end
  // advance opportunity, step bookkeeping and mode transitions
  always_comb begin
    opp = st == RUN || (st == ARMED && step);
    take = opp && !b.stall;
    pending_nxt = st == ARMED && step && !take && !b.run_mode;
    st_nxt = st;
    if (take && b.halt_req) st_nxt = HALT;
    else if (st == RUN) st_nxt = b.run_mode ? RUN : ARMED;
    else if (st == ARMED) st_nxt = b.run_mode ? RUN : take ? DONE : ARMED;
    else if (st == DONE) st_nxt = b.run_mode ? RUN : b.push ? DONE : ARMED;
  end
`else
  logic unused_step;
  assign unused_step = b.run_mode ^ b.push;
  // free-run only: advance every RUN cycle unless stalled, halt is sticky
  always_comb begin
    opp = st == RUN;
    take = opp && !b.stall;
    st_nxt = take && b.halt_req ? HALT : st;
  end
`endif
  assign adv = take & ~b.halt_req;
  // PC, advance pulse and state registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st     <= RUN;
      pc     <= RESET_PC;
      pc_adv <= 1'b0;
    end else begin
      st     <= st_nxt;
      pc_adv <= adv;
      if (adv) pc <= pc_nxt;
    end
  assign b.pc = pc;
  assign b.pc_adv = pc_adv;
  assign b.state = st;
  assign b.halted = st == HALT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer (step tests only with PC_STEP_EN)
module tb_pc_sequencer;
  import pc_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  pc_sequencer_if a ();
  pc_sequencer_if w ();
  pc_sequencer u0 (.clk(clk), .reset(reset), .b(a));
  pc_sequencer #(.RESET_PC(32'hFFFF_FFFE)) u1 (.clk(clk), .reset(reset), .b(w));
  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        adv;
    logic [1:0]  st;
  } exp_t;
  exp_t q[$];
  int ncmp = 0;
  int nerr = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    assert (got === want) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  task automatic cyc(input string tag, input logic [31:0] p, input logic adv, input logic [1:0] st);
    exp_t e;
    q.push_back('{tag, p, adv, st});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({e.tag, ".pc"}, a.pc, e.pc);
    chk({e.tag, ".adv"}, 32'(a.pc_adv), 32'(e.adv));
    chk({e.tag, ".state"}, 32'(a.state), 32'(e.st));
    chk({e.tag, ".halted"}, 32'(a.halted), 32'(e.st == 2'd3));
  endtask
  task automatic idle();
    a.run_mode = 1'b1; a.push = 1'b0; a.stall = 1'b0; a.branch_taken = 1'b0;
    a.branch_offset = '0; a.jump = 1'b0; a.jump_target = '0; a.halt_req = 1'b0;
  endtask
  initial begin
    idle();
    w.run_mode = 1'b1; w.push = 1'b0; w.stall = 1'b0; w.branch_taken = 1'b0;
    w.branch_offset = '0; w.jump = 1'b0; w.jump_target = '0; w.halt_req = 1'b0;
    #12;
    chk("rst.pc", a.pc, 32'h0);
    chk("rst.adv", 32'(a.pc_adv), 32'h0);
    chk("rst.state", 32'(a.state), 32'h0);
    chk("rst.halted", 32'(a.halted), 32'h0);
    chk("rst.wpc", w.pc, 32'hFFFF_FFFE);
    reset = 1'b1;
    cyc("run1", 32'd1, 1'b1, RUN); chk("wrap1", w.pc, 32'hFFFF_FFFF);
    cyc("run2", 32'd2, 1'b1, RUN); chk("wrap2", w.pc, 32'h0000_0000);
    cyc("run3", 32'd3, 1'b1, RUN); chk("wrap3", w.pc, 32'h0000_0001);
    cyc("run4", 32'd4, 1'b1, RUN);
    for (int i = 5; i <= 10; i++) cyc("run", i, 1'b1, RUN);
    a.branch_taken = 1'b1; a.branch_offset = -32'sd3;
    cyc("br_neg", 32'd8, 1'b1, RUN);
    a.branch_taken = 1'b0; a.jump = 1'b1; a.jump_target = 26'h100;
    cyc("jump", 32'h100, 1'b1, RUN);
    a.branch_taken = 1'b1; a.branch_offset = 32'd5; a.jump_target = 26'h200;
    cyc("jmp_over_br", 32'h200, 1'b1, RUN);
    a.stall = 1'b1;
    cyc("stall", 32'h200, 1'b0, RUN);
    idle();
    cyc("after_stall", 32'h201, 1'b1, RUN);
    a.branch_taken = 1'b1; a.branch_offset = 32'h0FFF_FDFE;
    cyc("br_far", 32'h1000_0000, 1'b1, RUN);
    a.branch_taken = 1'b0; a.jump = 1'b1; a.jump_target = 26'h5;
    cyc("jmp_hi", 32'h1000_0005, 1'b1, RUN);
    a.jump = 1'b0; a.branch_taken = 1'b1; a.branch_offset = 32'hEFFF_FFFA;
    cyc("br_back0", 32'h0, 1'b1, RUN);
    a.branch_offset = 32'hFFFF_FFFE;
    cyc("br_wrapneg", 32'hFFFF_FFFF, 1'b1, RUN);
    a.branch_taken = 1'b0; a.jump = 1'b1; a.jump_target = 26'h28;
    cyc("jmp_wrap", 32'h28, 1'b1, RUN);
    a.halt_req = 1'b1;
    cyc("halt", 32'h28, 1'b0, HALT);
    idle(); a.run_mode = 1'b0; a.push = 1'b1;
    cyc("halt_stick1", 32'h28, 1'b0, HALT);
    a.run_mode = 1'b1; a.push = 1'b0; a.jump = 1'b1;
    cyc("halt_stick2", 32'h28, 1'b0, HALT);
    a.push = 1'b1; a.run_mode = 1'b0;
    cyc("halt_stick3", 32'h28, 1'b0, HALT);
    idle();
    #2 reset = 1'b0;
    #1;
    chk("arst.pc", a.pc, 32'h0);
    chk("arst.state", 32'(a.state), 32'h0);
    chk("arst.halted", 32'(a.halted), 32'h0);
    chk("arst.adv", 32'(a.pc_adv), 32'h0);
    chk("arst.wpc", w.pc, 32'hFFFF_FFFE);
    #2 reset = 1'b1;
    for (int i = 1; i <= 4; i++) cyc("rerun", i, 1'b1, RUN);
`ifdef PC_STEP_EN
    a.run_mode = 1'b0;
    cyc("to_armed", 32'd5, 1'b1, ARMED);
    a.push = 1'b1;
    cyc("step_hold0", 32'd6, 1'b1, DONE);
    for (int i = 1; i < 6; i++) cyc("step_hold", 32'd6, 1'b0, DONE);
    a.push = 1'b0;
    cyc("release", 32'd6, 1'b0, ARMED);
    a.push = 1'b1;
    cyc("press2", 32'd7, 1'b1, DONE);
    a.push = 1'b0;
    cyc("release2", 32'd7, 1'b0, ARMED);
    a.run_mode = 1'b1;
    cyc("to_run", 32'd7, 1'b0, RUN);
    for (int i = 8; i <= 19; i++) cyc("run_s", i, 1'b1, RUN);
    a.run_mode = 1'b0;
    cyc("to_armed2", 32'd20, 1'b1, ARMED);
    a.stall = 1'b1; a.push = 1'b1;
    cyc("st_press", 32'd20, 1'b0, ARMED);
    a.push = 1'b0;
    cyc("st_hold1", 32'd20, 1'b0, ARMED);
    cyc("st_hold2", 32'd20, 1'b0, ARMED);
    a.stall = 1'b0;
    cyc("st_fire", 32'd21, 1'b1, DONE);
    cyc("st_rearm", 32'd21, 1'b0, ARMED);
    cyc("st_clear", 32'd21, 1'b0, ARMED);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
